fifo_arb_ctrl: RTL and testbench

FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_arb_ctrl_if.sv | 22 ++
 rtl/fifo_arb_pick.sv | 36 +++
 rtl/fifo_arb_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_arb_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO arbitration controller: state encodings,
// size defaults and where the destination index lives inside a word.
package fifo_arb_pkg;

  localparam int WORD_SIZE_DEF = 10;
  localparam int PTR_DEF       = 3;
  localparam int N_PORTS       = 4;
  localparam int IDX_W         = 2;
  // destination index occupies the top DEST_W bits of every word
  localparam int DEST_W        = 2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  function automatic int unsigned dest_lsb(input int unsigned word_size);
    return word_size - DEST_W;
  endfunction

endpackage

// File: rtl/fifo_arb_ctrl_if.sv
// Source/destination FIFO handshake bundle for fifo_arb_ctrl.
// master = controller side, slave = FIFO side.
interface fifo_arb_ctrl_if #(
  parameter int WORD_SIZE = fifo_arb_pkg::WORD_SIZE_DEF
);
  logic [fifo_arb_pkg::N_PORTS-1:0]           in_empty;
  logic [fifo_arb_pkg::N_PORTS*WORD_SIZE-1:0] in_data;
  logic [fifo_arb_pkg::N_PORTS-1:0]           in_rd;
  logic [fifo_arb_pkg::N_PORTS-1:0]           out_almost_full;
  logic [fifo_arb_pkg::N_PORTS-1:0]           out_wr;
  logic [WORD_SIZE-1:0]                       out_data;

  modport master (
    input  in_empty, in_data, out_almost_full,
    output in_rd, out_wr, out_data
  );

  modport slave (
    output in_empty, in_data, out_almost_full,
    input  in_rd, out_wr, out_data
  );
endinterface

// File: rtl/fifo_arb_pick.sv
// Combinational grant selection among the source FIFOs.
// Round-robin by default; FIFO_ARB_STRICT_PRIO_EN selects fixed priority (0 highest).
module fifo_arb_pick
  import fifo_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [N_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               valid
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = IDX_W'(i);
        valid   = 1'b1;
      end
    end
`else
    // scan farthest-to-nearest so the nearest requester after last_grant wins
    for (int unsigned off = N_PORTS; off >= 1; off--) begin
      if (req[last_grant + IDX_W'(off)]) begin
        gnt_idx = last_grant + IDX_W'(off);
        valid   = 1'b1;
      end
    end
`endif
    if (valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Moves words from 4 source FIFOs to 4 destination FIFOs chosen by each word's top bits.
// Optional FIFO_ARB_STRICT_PRIO_EN swaps round-robin for fixed priority in fifo_arb_pick.
module fifo_arb_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int PTR       = PTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [PTR-1:0]  full_th_in,
  input  logic [PTR-1:0]  empty_th_in,
  output logic [PTR-1:0]  full_threshold,
  output logic [PTR-1:0]  empty_threshold,
  input  logic [7:0]      fifo_error,
  output logic [2:0]      state,
  output logic            idle,
  fifo_arb_ctrl_if.master bus
);

  localparam int DEST_LSB = int'(dest_lsb(WORD_SIZE));

  state_e               cur, nxt;
  logic                 err_any, all_empty;
  logic [N_PORTS-1:0]   req, gnt, wr_vec;
  logic [IDX_W-1:0]     gnt_idx, last_grant, pend_idx;
  logic                 gnt_valid, pop, pend, wr_fire;
  logic [WORD_SIZE-1:0] pend_word, held_data;
  logic [DEST_W-1:0]    dest;

  assign err_any   = |fifo_error;
  assign all_empty = &bus.in_empty;
  assign req       = ~bus.in_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= ST_RESET;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_RESET:  nxt = ST_INIT;
      ST_INIT:   if (err_any) nxt = ST_ERROR;
                 else if (!init) nxt = ST_IDLE;
      ST_IDLE:   if (err_any) nxt = ST_ERROR;
                 else if (init) nxt = ST_INIT;
                 else if (!all_empty) nxt = ST_ACTIVE;
      ST_ACTIVE: if (err_any) nxt = ST_ERROR;
                 else if (init) nxt = ST_INIT;
                 else if (all_empty) nxt = ST_IDLE;
      ST_ERROR:  nxt = ST_ERROR;
      default:   nxt = ST_RESET;
    endcase
  end

  fifo_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .valid      (gnt_valid)
  );

  assign pop       = (cur == ST_ACTIVE) && gnt_valid && !(|bus.out_almost_full);
  assign bus.in_rd = pop ? gnt : '0;

  // a pop at t lands on the source's data_out at t+1, so the write uses in_data live
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_threshold  <= '0;
      empty_threshold <= '0;
      last_grant      <= IDX_W'(N_PORTS - 1);
      pend            <= 1'b0;
      pend_idx        <= '0;
      held_data       <= '0;
    end else begin
      if (cur == ST_INIT) begin
        full_threshold  <= full_th_in;
        empty_threshold <= empty_th_in;
      end
      if (pop) last_grant <= gnt_idx;
      pend     <= pop;
      pend_idx <= gnt_idx;
      if (wr_fire) held_data <= pend_word;
    end
  end

  assign wr_fire   = pend && (cur != ST_ERROR);
  assign pend_word = bus.in_data[int'(pend_idx)*WORD_SIZE +: WORD_SIZE];
  assign dest      = pend_word[DEST_LSB +: DEST_W];

  always_comb begin
    wr_vec = '0;
    if (wr_fire) wr_vec[dest] = 1'b1;
  end

  assign bus.out_wr   = wr_vec;
  assign bus.out_data = wr_fire ? pend_word : held_data;
  assign state        = cur;
  assign idle         = (cur == ST_IDLE);

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Randomised bench for fifo_arb_ctrl: queue-based source FIFOs and a rule-level
// reference model compared against the DUT every cycle, plus fixed scenarios.
module tb_fifo_arb_ctrl;
  localparam int W = 10;
  localparam int P = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, init;
  logic [P-1:0] full_th_in, empty_th_in, full_threshold, empty_threshold;
  logic [7:0]   fifo_error;
  logic [2:0]   state;
  logic         idle;

  fifo_arb_ctrl_if #(.WORD_SIZE(W)) bus ();

  fifo_arb_ctrl #(.WORD_SIZE(W), .PTR(P)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .full_th_in      (full_th_in),
    .empty_th_in     (empty_th_in),
    .full_threshold  (full_threshold),
    .empty_threshold (empty_threshold),
    .fifo_error      (fifo_error),
    .state           (state),
    .idle            (idle),
    .bus             (bus.master)
  );

  // stimulus requests applied at the next step
  logic         s_reset, s_init;
  logic [P-1:0] s_fth, s_eth;
  logic [7:0]   s_err;
  logic [3:0]   s_af;

  // source FIFO environment
  logic [W-1:0] srcq [4][$];
  logic [W-1:0] env_dout [4];

  // reference model
  int           m_state, m_last, m_pend_k, pop_k;
  bit           m_pend, pop_pend;
  logic [W-1:0] m_held;
  logic [P-1:0] m_fth, m_eth;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit src_empty(input int k);
    return srcq[k].size() == 0;
  endfunction

  task automatic model_check();
    logic [3:0]   e_rd, e_wr;
    logic [W-1:0] e_data, word;
    logic [1:0]   d;
    bit           wr, pop, any_ne, all_e, err;
    int           k;
    if (!reset) begin
      m_state = 0; m_last = 3; m_pend = 0; m_pend_k = 0; m_held = '0;
      m_fth = '0; m_eth = '0; pop_pend = 0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_idle", 32'(idle), 32'd0);
      chk("rst_in_rd", 32'(bus.in_rd), 32'd0);
      chk("rst_out_wr", 32'(bus.out_wr), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_full_th", 32'(full_threshold), 32'd0);
      chk("rst_empty_th", 32'(empty_threshold), 32'd0);
      return;
    end
    any_ne = 0;
    for (int i = 0; i < 4; i++) if (!src_empty(i)) any_ne = 1;
    all_e = !any_ne;
    err   = (fifo_error != 0);

    // write completing this cycle: the word the model popped last cycle
    wr     = m_pend && (m_state != 4);
    word   = env_dout[m_pend_k];
    d      = word[W-1 -: 2];
    e_wr   = wr ? (4'b0001 << d) : 4'b0000;
    e_data = wr ? word : m_held;

    pop = 0; k = 0;
    if (m_state == 3 && any_ne && s_af == 4'b0000) begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
      for (int j = 3; j >= 0; j--) if (!src_empty(j)) k = j;
      pop = 1;
`else
      for (int j = 1; j <= 4 && !pop; j++) begin
        if (!src_empty((m_last + j) % 4)) begin
          k = (m_last + j) % 4;
          pop = 1;
        end
      end
`endif
    end
    e_rd = pop ? (4'b0001 << k) : 4'b0000;

    chk("state", 32'(state), 32'(m_state));
    chk("idle", 32'(idle), 32'(m_state == 2));
    chk("full_th", 32'(full_threshold), 32'(m_fth));
    chk("empty_th", 32'(empty_threshold), 32'(m_eth));
    chk("in_rd", 32'(bus.in_rd), 32'(e_rd));
    chk("out_wr", 32'(bus.out_wr), 32'(e_wr));
    chk("out_data", 32'(bus.out_data), 32'(e_data));

    if (wr) m_held = word;
    m_pend = pop;
    if (pop) begin m_pend_k = k; m_last = k; end
    if (m_state == 1) begin m_fth = full_th_in; m_eth = empty_th_in; end
    case (m_state)
      0: m_state = 1;
      1: m_state = err ? 4 : (init ? 1 : 2);
      2: m_state = err ? 4 : (init ? 1 : (any_ne ? 3 : 2));
      3: m_state = err ? 4 : (init ? 1 : (all_e ? 2 : 3));
      default: m_state = 4;
    endcase
    pop_pend = pop;
    pop_k    = k;
  endtask

  // one clock cycle: apply FIFO pop and new stimulus just after the edge, check at negedge
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pend && srcq[pop_k].size() > 0) env_dout[pop_k] = srcq[pop_k].pop_front();
    pop_pend            = 0;
    reset               = s_reset;
    init                = s_init;
    full_th_in          = s_fth;
    empty_th_in         = s_eth;
    fifo_error          = s_err;
    bus.out_almost_full = s_af;
    for (int k = 0; k < 4; k++) begin
      bus.in_empty[k]      = src_empty(k);
      bus.in_data[k*W +: W] = env_dout[k];
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic bringup();
    s_reset = 1; s_init = 1; s_fth = 3'd6; s_eth = 3'd1;
    step(); chk("bring_s0", 32'(state), 32'd0);
    step(); chk("bring_s1", 32'(state), 32'd1);
    step();
    s_init = 0;
    step();
    step();
    chk("bring_state", 32'(state), 32'd2);
    chk("bring_fth", 32'(full_threshold), 32'd6);
    chk("bring_eth", 32'(empty_threshold), 32'd1);
    chk("bring_idle", 32'(idle), 32'd1);
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.in_rd != 0) break;
    end
  endtask

  task automatic push_rand(input int k);
    logic [W-1:0] w;
    w = W'($urandom);
    srcq[k].push_back(w);
  endtask

  task automatic drain(input int n);
    s_af = 0; s_init = 0; s_err = 0;
    repeat (n) step();
  endtask

  logic [3:0] seq [5];
  logic [3:0] exp_seq [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) env_dout[k] = '0;
    pop_pend = 0; pop_k = 0;
    m_state = 0; m_last = 3; m_pend = 0; m_pend_k = 0; m_held = '0; m_fth = '0; m_eth = '0;
    s_reset = 0; s_init = 0; s_fth = '0; s_eth = '0; s_err = '0; s_af = '0;
    init = 0; full_th_in = '0; empty_th_in = '0; fifo_error = '0;
    bus.in_empty = 4'hF; bus.in_data = '0; bus.out_almost_full = '0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // reset and bring-up
    repeat (3) step();
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    bringup();

    // basic single transfer from source 2 to destination 1
    srcq[2].push_back(10'b01_0000_1111);
    wait_rd();
    chk("basic_rd", 32'(bus.in_rd), 32'b0100);
    step();
    chk("basic_wr", 32'(bus.out_wr), 32'b0010);
    chk("basic_data", 32'(bus.out_data), 32'h10F);
    step(); step();
    chk("basic_idle", 32'(idle), 32'd1);

    // arbitration order from a fresh reset
    s_reset = 0; step(); step();
    bringup();
    for (int k = 0; k < 4; k++) repeat (3) push_rand(k);
`ifdef FIFO_ARB_STRICT_PRIO_EN
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001;
    exp_seq[3] = 4'b0010; exp_seq[4] = 4'b0010;
`else
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
`endif
    wait_rd();
    seq[0] = bus.in_rd;
    for (int i = 1; i < 5; i++) begin step(); seq[i] = bus.in_rd; end
    for (int i = 0; i < 5; i++) chk($sformatf("arb_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    drain(20);

    // backpressure with a write in flight
    for (int k = 0; k < 4; k++) repeat (3) push_rand(k);
    wait_rd();
    s_af = 4'b1000;
    step();
    chk("bp_pending_wr", 32'(bus.out_wr != 0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_rd", 32'(bus.in_rd), 32'd0);
      step();
    end
    s_af = 4'b0000;
    step();
    chk("bp_resume", 32'(bus.in_rd != 0), 32'd1);
    drain(20);

    // random traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 9) < 4) push_rand($urandom_range(0, 3));
      s_af   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      s_init = ($urandom_range(0, 59) == 0);
      s_fth  = P'($urandom);
      s_eth  = P'($urandom);
      step();
    end
    drain(30);

    // destination error during ACTIVE
    for (int k = 0; k < 4; k++) repeat (4) push_rand(k);
    wait_rd();
    s_err = 8'h20;
    step();
    s_err = 8'h00;
    step();
    chk("err_state", 32'(state), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("err_no_rd", 32'(bus.in_rd), 32'd0);
      chk("err_no_wr", 32'(bus.out_wr), 32'd0);
      step();
    end
    chk("err_stuck", 32'(state), 32'd4);
    s_reset = 0; step();
    chk("err_reset", 32'(state), 32'd0);
    bringup();

    // reset in the cycle after a read
    drain(20);
    for (int k = 0; k < 4; k++) repeat (2) push_rand(k);
    wait_rd();
    s_reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_wr", 32'(bus.out_wr), 32'd0);
      chk("midrst_data", 32'(bus.out_data), 32'd0);
      chk("midrst_state", 32'(state), 32'd0);
    end
    bringup();
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
